// File: rtl/lcd_bus_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : lcd_bus_ctrl_if
// Description : Byte-write handshake between the CPU side and the LCD
//               sequencer, plus the sticky init-complete indication.
// Revision    : 1.0 - initial release
// ============================================================================
interface lcd_bus_ctrl_if;
    logic       wr_valid;
    logic       wr_ready;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       init_done;

    modport master (
        output wr_valid,
        output wr_rs,
        output wr_data,
        input  wr_ready,
        input  init_done
    );

    modport slave (
        input  wr_valid,
        input  wr_rs,
        input  wr_data,
        output wr_ready,
        output init_done
    );
endinterface
`default_nettype wire

// File: rtl/lcd_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lcd_bus_ctrl
// Description : HD44780 write-only sequencer. Runs the power-on init ROM,
//               then writes requested bytes with setup / enable / execution
//               wait timing derived from fixed cycle counts.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_bus_ctrl #(
    parameter int T_SETUP   = 2,
    parameter int T_EN_HIGH = 12,
    parameter int T_CMD     = 2000,
    parameter int T_LONG    = 80000,
    parameter int T_POWERUP = 2000000
) (
    input  wire logic       clk,
    input  wire logic       reset,
    lcd_bus_ctrl_if.slave   req,
    output logic            lcd_en,
    output logic            lcd_rw,
    output logic            lcd_rs,
    output logic [7:0]      lcd_db
);

    localparam int MAX_A   = (T_SETUP > T_EN_HIGH) ? T_SETUP : T_EN_HIGH;
    localparam int MAX_B   = (T_CMD > T_LONG) ? T_CMD : T_LONG;
    localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_MAX = (MAX_C > T_POWERUP) ? MAX_C : T_POWERUP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Counters are loaded with N-1 so a phase of N cycles ends on the edge
    // where the counter reads zero.
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] ENHI_LOAD  = CNT_W'(T_EN_HIGH - 1);
    localparam logic [CNT_W-1:0] CMD_LOAD   = CNT_W'(T_CMD - 1);
    localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(T_LONG - 1);
    localparam logic [CNT_W-1:0] PWRUP_LOAD = CNT_W'(T_POWERUP - 1);
    localparam logic [2:0]       LAST_INIT  = 3'd5;

    // Loading a byte is not a separate registered state: it happens on the
    // edge that leaves PWRUP / WAIT / IDLE, so the accept edge is cycle 0.
    typedef enum logic [2:0] {
        S_PWRUP = 3'd0,
        S_SETUP = 3'd1,
        S_ENHI  = 3'd2,
        S_WAIT  = 3'd3,
        S_IDLE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;
    logic             rs_q, rs_d;
    logic [7:0]       db_q, db_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             long_q, long_d;
    logic [2:0]       idx_q, idx_d;
    logic             load;
    logic             load_rs;
    logic [7:0]       load_db;

    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: init_rom = 8'h38;
            3'd3:             init_rom = 8'h0C;
            3'd4:             init_rom = 8'h01;
            3'd5:             init_rom = 8'h06;
            default:          init_rom = 8'h00;
        endcase
    endfunction

    // Clear and return-home commands need the long execution wait.
    function automatic logic needs_long(input logic rs, input logic [7:0] db);
        needs_long = !rs && (db == 8'h01 || db == 8'h02 || db == 8'h03);
    endfunction

    // State, counter and all bus outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_PWRUP;
            cnt_q   <= PWRUP_LOAD;
            en_q    <= 1'b0;
            rs_q    <= 1'b0;
            db_q    <= 8'h00;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            long_q  <= 1'b0;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            rs_q    <= rs_d;
            db_q    <= db_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            long_q  <= long_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state and next-output decode, including the merged byte load.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        en_d    = en_q;
        rs_d    = rs_q;
        db_d    = db_q;
        ready_d = ready_q;
        done_d  = done_q;
        long_d  = long_q;
        idx_d   = idx_q;
        load    = 1'b0;
        load_rs = 1'b0;
        load_db = 8'h00;

        unique case (state_q)
            S_PWRUP: begin
                if (cnt_q == '0) begin
                    load    = 1'b1;
                    idx_d   = 3'd0;
                    load_db = init_rom(3'd0);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_ENHI;
                    en_d    = 1'b1;
                    cnt_d   = ENHI_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ENHI: begin
                if (cnt_q == '0) begin
                    state_d = S_WAIT;
                    en_d    = 1'b0;
                    cnt_d   = long_q ? LONG_LOAD : CMD_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    if (!done_q && idx_q != LAST_INIT) begin
                        load    = 1'b1;
                        idx_d   = 3'(idx_q + 3'd1);
                        load_db = init_rom(3'(idx_q + 3'd1));
                    end else begin
                        done_d  = 1'b1;
                        ready_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_IDLE: begin
                if (req.wr_valid && ready_q) begin
                    load    = 1'b1;
                    load_rs = req.wr_rs;
                    load_db = req.wr_data;
                    ready_d = 1'b0;
                end
            end
            default: begin
                state_d = S_PWRUP;
            end
        endcase

        if (load) begin
            state_d = S_SETUP;
            cnt_d   = SETUP_LOAD;
            rs_d    = load_rs;
            db_d    = load_db;
            long_d  = needs_long(load_rs, load_db);
        end
    end

    assign lcd_en        = en_q;
    assign lcd_rw        = 1'b0;
    assign lcd_rs        = rs_q;
    assign lcd_db        = db_q;
    assign req.wr_ready  = ready_q;
    assign req.init_done = done_q;

endmodule
`default_nettype wire
